// File: rtl/alu_out_demux.sv
// ============================================================================
// Module      : alu_out_demux
// Description : Write-back demux for the GF(2^163) ALU. Holds xa/xb/za/zb/zc,
//               steers ALU result pairs, host load port and 1-cycle readback.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_out_demux #(
    parameter int WIDTH = 163,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             res_valid,
    output logic             res_ready,
    input  logic [WIDTH-1:0] res_x,
    input  logic [WIDTH-1:0] res_z,
    input  logic             wr_x_en,
    input  logic             wr_xab,
    input  logic             wr_z_en,
    input  logic [1:0]       wr_z_sel,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [2:0]       ld_addr,
    input  logic [WIDTH-1:0] ld_data,
    input  logic             rd_req,
    input  logic [2:0]       rd_addr,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] xa,
    output logic [WIDTH-1:0] xb,
    output logic [WIDTH-1:0] za,
    output logic [WIDTH-1:0] zb,
    output logic [WIDTH-1:0] zc,
    output logic [CNT_W-1:0] wr_cnt,
    output logic             err
);

    localparam logic [2:0] c_ADDR_MAX = 3'd4;
    localparam logic [1:0] c_Z_BAD    = 2'b11;

    logic [WIDTH-1:0] r_xa, r_xb, r_za, r_zb, r_zc;
    logic [WIDTH-1:0] r_rd_data;
    logic             r_rd_valid;
    logic [CNT_W-1:0] r_wr_cnt;
    logic             r_err;

    logic             w_xfer;
    logic             w_x_wr;
    logic             w_z_wr;
    logic             w_z_bad;
    logic             w_cnt_inc;
    logic             w_ld;
    logic             w_ld_bad;
    logic             w_rd_bad;
    logic [WIDTH-1:0] w_rd_mux;

    assign res_ready = 1'b1;
    // ALU has priority; a load can only commit in a cycle with no ALU result.
    assign ld_ready  = ~res_valid;

    assign w_xfer    = res_valid & res_ready;
    assign w_x_wr    = w_xfer & wr_x_en;
    assign w_z_wr    = w_xfer & wr_z_en & (wr_z_sel != c_Z_BAD);
    assign w_z_bad   = w_xfer & wr_z_en & (wr_z_sel == c_Z_BAD);
    assign w_cnt_inc = w_xfer & (wr_x_en | wr_z_en);
    assign w_ld      = ld_valid & ld_ready;
    assign w_ld_bad  = w_ld & (ld_addr > c_ADDR_MAX);
    assign w_rd_bad  = rd_req & (rd_addr > c_ADDR_MAX);

    always_comb begin
        w_rd_mux = '0;
        case (rd_addr)
            3'd0:    w_rd_mux = r_xa;
            3'd1:    w_rd_mux = r_xb;
            3'd2:    w_rd_mux = r_za;
            3'd3:    w_rd_mux = r_zb;
            3'd4:    w_rd_mux = r_zc;
            default: w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_xa       <= '0;
            r_xb       <= '0;
            r_za       <= '0;
            r_zb       <= '0;
            r_zc       <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_wr_cnt   <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_x_wr) begin
                if (wr_xab) r_xa <= res_x;
                else        r_xb <= res_x;
            end
            if (w_z_wr) begin
                case (wr_z_sel)
                    2'b00:   r_za <= res_z;
                    2'b01:   r_zb <= res_z;
                    default: r_zc <= res_z;
                endcase
            end
            if (w_ld) begin
                case (ld_addr)
                    3'd0:    r_xa <= ld_data;
                    3'd1:    r_xb <= ld_data;
                    3'd2:    r_za <= ld_data;
                    3'd3:    r_zb <= ld_data;
                    3'd4:    r_zc <= ld_data;
                    default: ;
                endcase
            end
            // Readback samples pre-edge contents, so it sees the old value.
            r_rd_valid <= rd_req;
            if (rd_req) r_rd_data <= w_rd_mux;
            if (w_cnt_inc && (r_wr_cnt != {CNT_W{1'b1}}))
                r_wr_cnt <= r_wr_cnt + CNT_W'(1);
            r_err <= r_err | w_z_bad | w_ld_bad | w_rd_bad;
        end
    end

    assign xa       = r_xa;
    assign xb       = r_xb;
    assign za       = r_za;
    assign zb       = r_zb;
    assign zc       = r_zc;
    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;
    assign wr_cnt   = r_wr_cnt;
    assign err      = r_err;

endmodule

`default_nettype wire

// File: tb/tb_alu_out_demux.sv
// ============================================================================
// Module      : tb_alu_out_demux
// Description : Scoreboard bench for alu_out_demux: directed stimulus with
//               readback expectations queued and checked by a monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_out_demux;

    localparam int WIDTH = 163;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_x;
    logic [WIDTH-1:0] res_z;
    logic             wr_x_en;
    logic             wr_xab;
    logic             wr_z_en;
    logic [1:0]       wr_z_sel;
    logic             ld_valid;
    logic             ld_ready;
    logic [2:0]       ld_addr;
    logic [WIDTH-1:0] ld_data;
    logic             rd_req;
    logic [2:0]       rd_addr;
    logic             rd_valid;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] xa, xb, za, zb, zc;
    logic [CNT_W-1:0] wr_cnt;
    logic             err;

    int n_pass  = 0;
    int n_total = 0;
    logic [WIDTH-1:0] sb_q[$];

    alu_out_demux #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_x(res_x), .res_z(res_z),
        .wr_x_en(wr_x_en), .wr_xab(wr_xab), .wr_z_en(wr_z_en), .wr_z_sel(wr_z_sel),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
        .xa(xa), .xb(xb), .za(za), .zb(zb), .zc(zc),
        .wr_cnt(wr_cnt), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        res_valid = 0; wr_x_en = 0; wr_xab = 0; wr_z_en = 0; wr_z_sel = 0;
        ld_valid = 0; ld_addr = 0; rd_req = 0; rd_addr = 0;
    endtask

    task automatic read(input logic [2:0] a, input logic [WIDTH-1:0] exp);
        rd_req = 1; rd_addr = a;
        sb_q.push_back(exp);
    endtask

    // Monitor: every presented readback consumes one queued expectation.
    always @(negedge clk) begin
        if (rd_valid) begin
            if (sb_q.size() == 0) begin
                n_total++;
                $display("FAIL rd_unexpected: got rd_valid=1 data %h, expected no readback", rd_data);
            end else begin
                chk("rd_data", rd_data, sb_q.pop_front());
            end
        end
    end

    initial begin
        // T1: reset with every input asserted
        rst = 1; res_valid = 1; res_x = '1; res_z = '1; wr_x_en = 1; wr_xab = 1;
        wr_z_en = 1; wr_z_sel = 2'b11; ld_valid = 1; ld_addr = 3'd6; ld_data = '1;
        rd_req = 1; rd_addr = 3'd7;
        step(); step();
        chk("rst_xa", xa, 0); chk("rst_xb", xb, 0); chk("rst_za", za, 0);
        chk("rst_zb", zb, 0); chk("rst_zc", zc, 0);
        chk("rst_rd_valid", rd_valid, 0); chk("rst_rd_data", rd_data, 0);
        chk("rst_wr_cnt", wr_cnt, 0); chk("rst_err", err, 0);
        rst = 0; idle(); res_x = 0; res_z = 0; ld_data = 0;
        #1 chk("res_ready", res_ready, 1);

        // T2: back-to-back loads, then back-to-back reads
        for (int i = 0; i < 5; i++) begin
            ld_valid = 1; ld_addr = 3'(i); ld_data = WIDTH'(i + 1);
            step();
        end
        idle();
        chk("ld_zc", zc, 5);
        for (int i = 0; i < 5; i++) begin
            read(3'(i), WIDTH'(i + 1));
            step();
        end
        idle();
        step();
        chk("rd_idle_valid", rd_valid, 0);
        chk("rd_idle_hold", rd_data, 5);

        // T3: dual write, then a no-op transfer
        res_valid = 1; res_x = 163'hABC; wr_xab = 0; wr_x_en = 1;
        res_z = 163'h7; wr_z_sel = 2'b10; wr_z_en = 1;
        step();
        chk("t3_xb", xb, 163'hABC); chk("t3_zc", zc, 163'h7);
        chk("t3_xa", xa, 1); chk("t3_za", za, 3); chk("t3_zb", zb, 4);
        chk("t3_cnt", wr_cnt, 1);
        wr_x_en = 0; wr_z_en = 0; res_x = 163'h123; res_z = 163'h456;
        step();
        chk("noop_cnt", wr_cnt, 1); chk("noop_xb", xb, 163'hABC);

        // T4: collision between load and ALU write
        idle();
        res_valid = 1; wr_x_en = 1; wr_xab = 1; res_x = 163'h99;
        ld_valid = 1; ld_addr = 0; ld_data = 163'h55;
        #1 chk("t4_ld_ready_lo", ld_ready, 0);
        step();
        chk("t4_xa_alu", xa, 163'h99); chk("t4_cnt", wr_cnt, 2);
        res_valid = 0; wr_x_en = 0;
        #1 chk("t4_ld_ready_hi", ld_ready, 1);
        step();
        chk("t4_xa_ld", xa, 163'h55); chk("t4_err", err, 0);
        idle();

        // T5: illegal z select, illegal load address, illegal read address
        res_valid = 1; wr_x_en = 1; wr_xab = 1; res_x = 163'h11;
        wr_z_en = 1; wr_z_sel = 2'b11; res_z = 163'hDEAD;
        step();
        chk("t5_xa", xa, 163'h11); chk("t5_za", za, 3); chk("t5_zb", zb, 4);
        chk("t5_zc", zc, 163'h7); chk("t5_err", err, 1); chk("t5_cnt", wr_cnt, 3);
        idle();
        ld_valid = 1; ld_addr = 3'd6; ld_data = 163'hFF;
        step();
        idle();
        chk("t5_ld_xa", xa, 163'h11); chk("t5_ld_xb", xb, 163'hABC);
        chk("t5_ld_za", za, 3); chk("t5_ld_zb", zb, 4); chk("t5_ld_zc", zc, 163'h7);
        chk("t5_err_sticky", err, 1);
        read(3'd7, 0);
        step();
        idle();
        step();
        chk("t5_err_rd", err, 1);

        // T6: read-before-write, then counter saturation
        res_valid = 1; wr_x_en = 1; wr_xab = 1; res_x = 163'h22;
        read(3'd0, 163'h11);
        step();
        idle();
        chk("t6_xa", xa, 163'h22); chk("t6_cnt", wr_cnt, 4);
        for (int i = 0; i < 300; i++) begin
            res_valid = 1; wr_z_en = 1; wr_z_sel = 2'b00; res_z = WIDTH'(i);
            step();
            if (i == 249) chk("t6_cnt_254", wr_cnt, 254);
        end
        idle();
        chk("t6_cnt_sat", wr_cnt, 255);
        chk("t6_za_last", za, 163'd299);

        // Reset mid-operation overrides concurrent activity
        rst = 1; res_valid = 1; wr_x_en = 1; res_x = '1; ld_valid = 1; ld_data = '1;
        step();
        rst = 0; idle();
        chk("mid_rst_xa", xa, 0); chk("mid_rst_cnt", wr_cnt, 0); chk("mid_rst_err", err, 0);
        step(); step();
        chk("sb_drained", WIDTH'(sb_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
